ps2_rx: RTL
===========

Name: ps2_rx

Overview:
- PS/2 host-side receiver: deserialises device-to-host frames from the PS/2 bus into bytes.
- Frame format: start(0), 8 data LSB-first, odd parity, stop(1).
- Sits beside ps2_tx in the PS/2 interface. It observes the shared PS2_CLK/PS2_DATA nets as inputs only and never drives them.
- Feeds scan codes to the keyboard/mouse decode logic through a one-cycle valid strobe.

Parameters:
- TIMEOUT_CYC, 100000, clk_sys cycles (2 ms at 50 MHz) allowed between PS2_CLK falling edges mid-frame before the frame is aborted.
- FILT_LEN, 8, consecutive identical clk_sys samples required to accept a PS2_CLK level change (used only with the optional feature).

Ports:
- clk_sys  input  1  50 MHz system clock.
- rst_n  input  1  Asynchronous active-low reset.
- PS2_CLK  input  1  PS/2 clock net (observed; ps2_tx owns the tri-state).
- PS2_DATA  input  1  PS/2 data net (observed).
- rx_en  input  1  Receive enable; tie low while ps2_tx is busy.
- rd_valid  output  1  One-cycle pulse; rd_data holds a new good byte.
- rd_data  output  8  Last correctly received byte.
- rd_err  output  1  One-cycle pulse on parity, stop or timeout error.
- busy  output  1  High while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rd_valid=0, rd_data=8'h00, rd_err=0, busy=0, all counters and shift registers 0, synchroniser stages reset to 1 (bus idle high).
- Sync: PS2_CLK and PS2_DATA each pass through a 2-FF synchroniser.
  - clk_fall is a one-cycle pulse when the synced clock was 1 last cycle and is 0 now.
  - Data is sampled from the synced PS2_DATA in the same cycle as clk_fall.
- FSM states: IDLE, DATA, PARITY, STOP (encoding from package).
  - IDLE: on clk_fall with data=0, go to DATA with bit_cnt=0 and shift=0. On clk_fall with data=1 (spurious start), stay in IDLE with no error.
  - DATA: on each clk_fall, shift = {data, shift[7:1]} and bit_cnt++. On the 8th edge (bit_cnt==7), go to PARITY.
  - PARITY: on clk_fall, latch par_bit and go to STOP.
  - STOP: on clk_fall, evaluate the frame and return to IDLE.
    - If data==1 and (^shift ^ par_bit)==1 (odd parity holds): rd_data<=shift and rd_valid<=1.
    - Otherwise: rd_err<=1 and rd_data is unchanged.
- Latency: rd_valid/rd_err rise one clk_sys cycle after the cycle in which the stop-bit clk_fall is detected. That is 3 cycles after the raw PS2_CLK falling edge (2 sync + 1 register). Each pulse lasts exactly 1 cycle.
- Timeout: tmo_cnt clears on every clk_fall and in IDLE, and increments otherwise. When tmo_cnt reaches TIMEOUT_CYC-1 in a non-IDLE state: go to IDLE, pulse rd_err one cycle later, and discard the partial byte. The counter saturates and never wraps.
- rx_en=0: state is forced to IDLE and counters clear. An in-progress frame is aborted silently (no rd_err). No rd_valid or rd_err is generated while rx_en=0. Reception resumes on the first valid start edge after rx_en returns to 1.
- Simultaneous clk_fall and timeout terminal count: clk_fall wins and the counter clears.
- Simultaneous rx_en falling and the stop edge: rx_en wins and no output pulse is generated.
- rd_valid and rd_err are never high in the same cycle.
- busy is combinational from state.

Optional Feature:
- Macro: PS2_RX_GLITCH_FILTER_EN.
- Defined: the synced PS2_CLK goes through a debounce stage. The filtered level changes only after FILT_LEN consecutive samples of the new value. This adds FILT_LEN cycles of latency to clk_fall, and pulses shorter than FILT_LEN cycles are ignored.
- Undefined: the filter is absent and clk_fall is derived directly from the 2-FF synchroniser output.
- PS2_DATA is never filtered in either configuration.

Decomposition:
- Package ps2_pkg holds:
  - the rx state enum (IDLE/DATA/PARITY/STOP, one-hot);
  - PS2_DATA_BITS=8;
  - the default TIMEOUT_CYC constant;
  - a function odd_parity(byte) shared with ps2_tx.
- One sub-module, ps2_clk_filter: synchroniser plus optional debounce plus falling-edge detect. It outputs clk_fall and the synced data, and is instantiated once inside ps2_rx.

Test Plan:
- Frame 0x1C, parity 0, stop 1, PS2_CLK period 80 us, rx_en=1 -> one rd_valid pulse 3 cycles after the stop falling edge, rd_data=8'h1C, rd_err never asserted.
- Back-to-back frames 0xF0 (parity 1) then 0x1C (parity 0), 100 us gap between them -> two rd_valid pulses, rd_data=8'hF0 then 8'h1C.
- Frame 0xAA with parity bit 0 (wrong) -> rd_err one-cycle pulse, no rd_valid, rd_data keeps its prior value (8'h00 after reset).
- Frame 0x55 with stop bit 0 -> rd_err pulse. Then a valid 0x12 frame -> rd_valid with rd_data=8'h12.
- Start plus 3 data bits, then PS2_CLK held high for 2.5 ms -> rd_err pulse once tmo_cnt hits 99999, state IDLE, busy=0. A following full 0x1C frame is received correctly.
- rx_en dropped after bit 4 of 0x1C and raised 1 ms later -> no rd_valid, no rd_err, busy=0. Then:
  - a 0x5A frame -> rd_data=8'h5A;
  - with PS2_RX_GLITCH_FILTER_EN defined, a 3-cycle low glitch on idle PS2_CLK -> no state change.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared PS/2 definitions: receiver state encoding (one-hot),
//                frame data width, default frame timeout and the odd-parity
//                helper used by both ps2_rx and ps2_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  localparam int PS2_DATA_BITS   = 8;
  localparam int PS2_TIMEOUT_CYC = 100000;  // 2 ms at 50 MHz

  // Receiver states, one-hot
  localparam logic [3:0] c_ST_IDLE   = 4'b0001;
  localparam logic [3:0] c_ST_DATA   = 4'b0010;
  localparam logic [3:0] c_ST_PARITY = 4'b0100;
  localparam logic [3:0] c_ST_STOP   = 4'b1000;

  // Parity bit value that makes data plus parity contain an odd number of ones
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] i_byte);
    return ~(^i_byte);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_clk_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_clk_filter
//  Description : 2-FF synchronisers for PS2_CLK / PS2_DATA, optional debounce
//                of the synced clock, and falling-edge detection.
//                Optional feature macro: PS2_RX_GLITCH_FILTER_EN
//                  defined   - synced clock level changes only after FILT_LEN
//                              consecutive samples of the new value
//                  undefined - edge detect works on the synchroniser output
//  Ports       : clk_sys     in   system clock
//                rst_n       in   asynchronous active-low reset
//                i_ps2_clk   in   raw PS/2 clock net
//                i_ps2_data  in   raw PS/2 data net
//                o_clk_fall  out  one-cycle pulse on a PS/2 clock falling edge
//                o_data      out  synchronised PS/2 data (never filtered)
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_clk_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_fall,
  output logic o_data
);

  logic r_clk_s1, r_clk_s2;
  logic r_dat_s1, r_dat_s2;
  logic r_lvl_d;
  logic w_lvl;

  // Synchroniser stages reset high: idle bus level
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int c_CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [c_CW-1:0] r_filt_cnt;
  logic            r_filt_lvl;

  // Count consecutive samples disagreeing with the accepted level; any
  // agreeing sample restarts the count, so short pulses never get through.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_cnt <= '0;
      r_filt_lvl <= 1'b1;
    end else if (r_clk_s2 == r_filt_lvl) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == c_CW'(FILT_LEN - 1)) begin
      r_filt_lvl <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_lvl = r_filt_lvl;
`else
  assign w_lvl = r_clk_s2;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl_d <= 1'b1;
    end else begin
      r_lvl_d <= w_lvl;
    end
  end

  assign o_clk_fall = r_lvl_d & ~w_lvl;
  assign o_data     = r_dat_s2;

endmodule
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx
//  Description : PS/2 host-side receiver. Deserialises device-to-host frames
//                (start 0, 8 data LSB-first, odd parity, stop 1) into bytes.
//                Observes PS2_CLK / PS2_DATA only, never drives them.
//                Optional feature macro: PS2_RX_GLITCH_FILTER_EN (debounce of
//                the synchronised PS2_CLK, see ps2_clk_filter).
//  Ports       : clk_sys   in   50 MHz system clock
//                rst_n     in   asynchronous active-low reset
//                PS2_CLK   in   PS/2 clock net
//                PS2_DATA  in   PS/2 data net
//                rx_en     in   receive enable (low while ps2_tx is busy)
//                rd_valid  out  one-cycle pulse, rd_data holds a new byte
//                rd_data   out  last correctly received byte
//                rd_err    out  one-cycle pulse on parity/stop/timeout error
//                busy      out  frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC,
  parameter int FILT_LEN    = 8
) (
  input  logic                     clk_sys,
  input  logic                     rst_n,
  input  logic                     PS2_CLK,
  input  logic                     PS2_DATA,
  input  logic                     rx_en,
  output logic                     rd_valid,
  output logic [PS2_DATA_BITS-1:0] rd_data,
  output logic                     rd_err,
  output logic                     busy
);

  localparam int c_TW = $clog2(TIMEOUT_CYC + 1);
  localparam int c_BW = $clog2(PS2_DATA_BITS);

  logic                     w_clk_fall;
  logic                     w_data;
  logic                     w_tmo_hit;

  logic [3:0]               r_state;
  logic [c_BW-1:0]          r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic                     r_par;
  logic [c_TW-1:0]          r_tmo;
  logic                     r_valid;
  logic                     r_err;
  logic [PS2_DATA_BITS-1:0] r_data;

  ps2_clk_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_clk_filter (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .i_ps2_clk  (PS2_CLK),
    .i_ps2_data (PS2_DATA),
    .o_clk_fall (w_clk_fall),
    .o_data     (w_data)
  );

  assign w_tmo_hit = (r_tmo == c_TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tmo     <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_data    <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (!rx_en) begin
        // Silent abort: takes priority over a coincident stop edge
        r_state   <= c_ST_IDLE;
        r_bit_cnt <= '0;
        r_tmo     <= '0;
      end else if (r_state == c_ST_IDLE) begin
        r_tmo <= '0;
        // A falling edge with data high is a spurious start and is ignored
        if (w_clk_fall && !w_data) begin
          r_state   <= c_ST_DATA;
          r_bit_cnt <= '0;
          r_shift   <= '0;
        end
      end else if (w_clk_fall) begin
        // An edge beats a coincident timeout terminal count
        r_tmo <= '0;
        case (r_state)
          c_ST_DATA: begin
            r_shift   <= {w_data, r_shift[PS2_DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == c_BW'(PS2_DATA_BITS - 1)) begin
              r_state <= c_ST_PARITY;
            end
          end
          c_ST_PARITY: begin
            r_par   <= w_data;
            r_state <= c_ST_STOP;
          end
          c_ST_STOP: begin
            r_state <= c_ST_IDLE;
            if (w_data && (r_par == odd_parity(r_shift))) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: r_state <= c_ST_IDLE;
        endcase
      end else if (w_tmo_hit) begin
        // Device stalled mid-frame: drop the partial byte
        r_state <= c_ST_IDLE;
        r_tmo   <= '0;
        r_err   <= 1'b1;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  assign rd_valid = r_valid;
  assign rd_err   = r_err;
  assign rd_data  = r_data;
  assign busy     = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
